// File: rtl/jtvigil_snd_rom_arb.sv
// Sound-board ROM arbiter: one SDRAM read slot shared by Z80 fetches and PCM sample reads.
// Define JTVIGIL_PCM_PREFETCH_EN to add a one-byte PCM prefetch of the next sample address.
module jtvigil_snd_rom_arb #(
    parameter int             AW       = 22,
    parameter logic [AW-1:0]  CPU_BASE = 22'h00000,
    parameter logic [AW-1:0]  PCM_BASE = 22'h10000
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cpu_cs,
    input  logic [15:0]   cpu_addr,
    output logic [7:0]    cpu_data,
    output logic          cpu_ok,
    input  logic [15:0]   pcm_addr,
    input  logic          pcm_step,
    output logic [7:0]    pcm_data,
    output logic          pcm_ok,
    output logic          sd_cs,
    output logic [AW-1:0] sd_addr,
    input  logic [7:0]    sd_data,
    input  logic          sd_ok
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] CPU_RD  = 2'd1;
    localparam logic [1:0] PCM_RD  = 2'd2;
`ifdef JTVIGIL_PCM_PREFETCH_EN
    localparam logic [1:0] PREF_RD = 2'd3;
`endif

    // Handshake: sd_cs is held with a constant sd_addr until sd_ok; the edge that
    // samples sd_ok stores the byte and returns to IDLE, so sd_cs falls on that edge.
    logic [1:0]  state;
    logic        rr_last;      // 0: CPU was served last, 1: PCM
    logic [15:0] lat_addr;
    logic [15:0] cpu_tag;
    logic        cpu_val;
    logic [15:0] pcm_tag;
    logic        pcm_val;
    logic        pref_hit;
    logic        cpu_pend;
    logic        pcm_pend;

`ifdef JTVIGIL_PCM_PREFETCH_EN
    logic [15:0] ptag;
    logic [7:0]  pdata;
    logic        pvalid;
    logic [15:0] next_pcm;

    assign next_pcm = pcm_tag + 16'd1;
    assign pref_hit = pvalid && (ptag == pcm_addr);
`else
    assign pref_hit = 1'b0;
`endif

    assign cpu_ok   = cpu_val && (cpu_tag == cpu_addr) && cpu_cs;
    assign pcm_ok   = pcm_val && (pcm_tag == pcm_addr);
    assign cpu_pend = cpu_cs && !cpu_ok;
    assign pcm_pend = !pcm_ok && !pref_hit;
    assign sd_cs    = (state != IDLE);

    // pcm_step is informational: a step is visible as a change of pcm_addr against the tags
    logic unused_step;
    assign unused_step = pcm_step;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            rr_last  <= 1'b0;
            lat_addr <= '0;
            sd_addr  <= '0;
            cpu_tag  <= '0;
            cpu_data <= '0;
            cpu_val  <= 1'b0;
            pcm_tag  <= '0;
            pcm_data <= '0;
            pcm_val  <= 1'b0;
`ifdef JTVIGIL_PCM_PREFETCH_EN
            ptag     <= '0;
            pdata    <= '0;
            pvalid   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
`ifdef JTVIGIL_PCM_PREFETCH_EN
                    if (pref_hit) begin
                        pcm_tag  <= ptag;
                        pcm_data <= pdata;
                        pcm_val  <= 1'b1;
                        pvalid   <= 1'b0;
                    end else
`endif
                    if (cpu_pend && (!pcm_pend || rr_last)) begin
                        state    <= CPU_RD;
                        lat_addr <= cpu_addr;
                        sd_addr  <= CPU_BASE + {{(AW-16){1'b0}}, cpu_addr};
                    end else if (pcm_pend) begin
                        state    <= PCM_RD;
                        lat_addr <= pcm_addr;
                        sd_addr  <= PCM_BASE + {{(AW-16){1'b0}}, pcm_addr};
`ifdef JTVIGIL_PCM_PREFETCH_EN
                        // a demand miss means the prefetched byte is off-sequence
                        pvalid   <= 1'b0;
`endif
                    end
`ifdef JTVIGIL_PCM_PREFETCH_EN
                    else if (!pvalid && pcm_val) begin
                        state    <= PREF_RD;
                        lat_addr <= next_pcm;
                        sd_addr  <= PCM_BASE + {{(AW-16){1'b0}}, next_pcm};
                    end
`endif
                end
                CPU_RD: begin
                    if (sd_ok) begin
                        cpu_tag  <= lat_addr;
                        cpu_data <= sd_data;
                        cpu_val  <= 1'b1;
                        rr_last  <= 1'b0;
                        state    <= IDLE;
                    end
                end
                PCM_RD: begin
                    if (sd_ok) begin
                        pcm_tag  <= lat_addr;
                        pcm_data <= sd_data;
                        pcm_val  <= 1'b1;
                        rr_last  <= 1'b1;
                        state    <= IDLE;
                    end
                end
`ifdef JTVIGIL_PCM_PREFETCH_EN
                PREF_RD: begin
                    if (sd_ok) begin
                        ptag   <= lat_addr;
                        pdata  <= sd_data;
                        pvalid <= 1'b1;
                        state  <= IDLE;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule
